mm_control_multi: RTL and testbench
===================================

# mm_control_multi

Parametrised memory-mapped control unit that launches and supervises `CORES` independent videocard cores from one narrow control bus. It sits between the HPS-side control slave and the core array: host writes a start mask, the block pulses each selected core's `interrupt_start`, tracks per-core busy/done, runs a per-core watchdog, and raises a maskable host interrupt. It supersedes the single-core control unit by adding channel count, a sticky done/timeout status, an interrupt enable mask and a timeout.

## Interface
- `CORES`, 4: number of supervised cores; 1..`WIDTH_CTRL`.
- `WIDTH_CTRL`, 8: control data width.
- `TIMEOUT_W`, 16: watchdog counter width.
- `TIMEOUT`, 50000: cycles in BUSY before a core is declared hung; 1..2^`TIMEOUT_W`-1.

Ports:
- `clk`  in  1  single clock for everything.
- `reset_sink_reset_n`  in  1  asynchronous, active-low reset.
- `address_control`  in  2  register select.
- `read_control`  in  1  read strobe.
- `write_control`  in  1  write strobe.
- `data_in_control`  in  `WIDTH_CTRL`  write data.
- `data_out_control`  out  `WIDTH_CTRL`  read data, registered.
- `interrupt_start`  out  `CORES`  one-cycle start pulse per core.
- `interrupt_finish`  in  `CORES`  per-core finish; level or pulse, sampled each cycle.
- `irq`  out  1  host interrupt, registered.

## Operation
- Register map (unused high bits read 0, writes ignored):
  - 0 START/BUSY: write bit i=1 starts core i; read returns busy mask.
  - 1 DONE: sticky finished mask; write-1-to-clear.
  - 2 IRQ_EN: read/write enable mask, reset 0.
  - 3 TIMEOUT: sticky hung mask; write-1-to-clear.
- Per-core FSM, states IDLE, LAUNCH, BUSY:
  - IDLE -> LAUNCH on START write with bit i=1; core i's DONE and TIMEOUT bits clear on that write.
  - LAUNCH: `interrupt_start[i]`=1, watchdog cleared; -> BUSY next cycle.
  - BUSY: watchdog increments each cycle; `interrupt_finish[i]`=1 -> IDLE, set DONE[i]; watchdog reaches `TIMEOUT` -> IDLE, set TIMEOUT[i].
- `irq` = OR over i of ((DONE[i] | TIMEOUT[i]) & IRQ_EN[i]).
- Boundary rules:
  - START bit for a core in LAUNCH or BUSY: ignored; state, status and watchdog unchanged.
  - `interrupt_finish` in IDLE or LAUNCH: ignored.
  - Finish and watchdog expiry in the same cycle: finish wins; DONE set, TIMEOUT not.
  - Hardware set and host W1C of the same bit in the same cycle: set wins.
  - Simultaneous read and write: write takes effect; read returns pre-write value.
  - Watchdog saturates; no wrap.
  - Reset mid-operation: all cores IDLE, no start pulse emitted; the core itself is not notified.

## Timing
- Reset values: `data_out_control`=0, `interrupt_start`=0, `irq`=0, all registers 0, all FSMs IDLE.
- Read latency 1: `data_out_control` valid the cycle after `read_control`, held until next read.
- START write at cycle t: `interrupt_start[i]` high exactly cycle t+1; busy reads 1 from t+1.
- Finish sampled at cycle u: busy=0 and DONE set at u+1; `irq` at u+2.
- Timeout: BUSY entered at t+2; expiry after `TIMEOUT` BUSY cycles; TIMEOUT bit visible the following cycle.
- Back-to-back: a core may be restarted by a write in the cycle after it returns to IDLE.

## Structure
- Package `mm_control_pkg`: register address constants (`REG_START`, `REG_DONE`, `REG_IRQ_EN`, `REG_TIMEOUT`), FSM state typedef.
- Sub-module `core_slot`: one FSM plus watchdog; outputs start pulse, busy, done_set, timeout_set; instantiated `CORES` times by generate.
- The top level holds the register file, read mux and irq reduction.

## Test plan
- Reset, then read all four registers -> each returns 0x00; `irq`=0.
- Set IRQ_EN=0x0F, write START=0x05, finish core 0 after 10 cycles -> single pulses on cores 0 and 2 at t+1; BUSY reads 0x05 then 0x04; DONE=0x01; `irq`=1; W1C 0x01 -> `irq`=0.
- With `TIMEOUT`=20, start core 1 and never finish -> TIMEOUT reads 0x02 after 20 BUSY cycles; BUSY=0x00.
- Start core 3, then write START=0x08 while busy -> no second pulse; watchdog not restarted.
- Finish core 2 in the same cycle as a W1C write of 0x04 to DONE -> DONE[2] reads 1.
- Deassert reset for 1 cycle while cores 0 and 1 are BUSY -> all registers 0, no `interrupt_start` pulse; a later finish is ignored.

Source files
------------

// File: rtl/mm_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_control_pkg
// Brief    : Register map and per-core FSM encoding for mm_control_multi.
// Revision : 1.0 - initial release
// ============================================================================
package mm_control_pkg;

    localparam logic [1:0] REG_START   = 2'd0;
    localparam logic [1:0] REG_DONE    = 2'd1;
    localparam logic [1:0] REG_IRQ_EN  = 2'd2;
    localparam logic [1:0] REG_TIMEOUT = 2'd3;

    typedef logic [1:0] slot_state_t;

    localparam slot_state_t ST_IDLE   = 2'd0;
    localparam slot_state_t ST_LAUNCH = 2'd1;
    localparam slot_state_t ST_BUSY   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/core_slot.sv
`default_nettype none
// ============================================================================
// Module   : core_slot
// Brief    : One supervised core: launch/busy FSM plus saturating watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module core_slot
    import mm_control_pkg::*;
#(
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 50000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_finish,
    output logic o_start_pulse,
    output logic o_busy,
    output logic o_idle,
    output logic o_done_set,
    output logic o_timeout_set
);

    // Expiry fires during the TIMEOUT-th BUSY cycle (watchdog counts from 0).
    localparam logic [TIMEOUT_W-1:0] c_expire = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] c_wd_max = {TIMEOUT_W{1'b1}};

    slot_state_t          r_state;
    slot_state_t          w_state_next;
    logic [TIMEOUT_W-1:0] r_wd;
    logic                 w_expire;

    assign w_expire = (r_wd >= c_expire);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_wd <= '0;
        end else if ((r_state == ST_BUSY) && (r_wd != c_wd_max)) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_state_next = ST_LAUNCH;
            ST_LAUNCH: w_state_next = ST_BUSY;
            ST_BUSY:   if (i_finish || w_expire) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Finish takes priority over a coincident watchdog expiry.
    always_comb begin
        o_start_pulse = (r_state == ST_LAUNCH);
        o_busy        = (r_state != ST_IDLE);
        o_idle        = (r_state == ST_IDLE);
        o_done_set    = (r_state == ST_BUSY) && i_finish;
        o_timeout_set = (r_state == ST_BUSY) && !i_finish && w_expire;
    end

endmodule
`default_nettype wire

// File: rtl/mm_control_multi.sv
`default_nettype none
// ============================================================================
// Module   : mm_control_multi
// Brief    : Memory-mapped launcher/supervisor for CORES videocard cores.
// Revision : 1.0 - initial release
// ============================================================================
module mm_control_multi
    import mm_control_pkg::*;
#(
    parameter int CORES      = 4,
    parameter int WIDTH_CTRL = 8,
    parameter int TIMEOUT_W  = 16,
    parameter int TIMEOUT    = 50000
) (
    input  logic                  clk,
    input  logic                  reset_sink_reset_n,
    input  logic [1:0]            address_control,
    input  logic                  read_control,
    input  logic                  write_control,
    input  logic [WIDTH_CTRL-1:0] data_in_control,
    output logic [WIDTH_CTRL-1:0] data_out_control,
    output logic [CORES-1:0]      interrupt_start,
    input  logic [CORES-1:0]      interrupt_finish,
    output logic                  irq
);

    logic [CORES-1:0]      w_start_req;
    logic [CORES-1:0]      w_launch;
    logic [CORES-1:0]      w_done_w1c;
    logic [CORES-1:0]      w_timeout_w1c;
    logic [CORES-1:0]      w_busy;
    logic [CORES-1:0]      w_idle;
    logic [CORES-1:0]      w_done_set;
    logic [CORES-1:0]      w_timeout_set;
    logic [CORES-1:0]      r_done;
    logic [CORES-1:0]      r_timeout;
    logic [CORES-1:0]      r_irq_en;
    logic                  r_irq;
    logic [WIDTH_CTRL-1:0] r_data_out;
    logic [WIDTH_CTRL-1:0] w_rd_data;

    always_comb begin
        w_start_req   = '0;
        w_done_w1c    = '0;
        w_timeout_w1c = '0;
        if (write_control) begin
            case (address_control)
                REG_START:   w_start_req   = data_in_control[CORES-1:0];
                REG_DONE:    w_done_w1c    = data_in_control[CORES-1:0];
                REG_TIMEOUT: w_timeout_w1c = data_in_control[CORES-1:0];
                default:     ;
            endcase
        end
    end

    // Only an accepted launch clears a core's sticky status.
    assign w_launch = w_start_req & w_idle;

    for (genvar gi = 0; gi < CORES; gi++) begin : g_slot
        core_slot #(
            .TIMEOUT_W (TIMEOUT_W),
            .TIMEOUT   (TIMEOUT)
        ) u_core_slot (
            .clk           (clk),
            .i_rst_n       (reset_sink_reset_n),
            .i_start       (w_start_req[gi]),
            .i_finish      (interrupt_finish[gi]),
            .o_start_pulse (interrupt_start[gi]),
            .o_busy        (w_busy[gi]),
            .o_idle        (w_idle[gi]),
            .o_done_set    (w_done_set[gi]),
            .o_timeout_set (w_timeout_set[gi])
        );
    end

    if (CORES < WIDTH_CTRL) begin : g_unused_bits
        logic w_unused_data;
        assign w_unused_data = ^data_in_control[WIDTH_CTRL-1:CORES];
    end

    // Hardware set overrides a same-cycle host clear.
    always_ff @(posedge clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_done    <= '0;
            r_timeout <= '0;
            r_irq_en  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_done    <= (r_done    & ~w_done_w1c    & ~w_launch) | w_done_set;
            r_timeout <= (r_timeout & ~w_timeout_w1c & ~w_launch) | w_timeout_set;
            if (write_control && (address_control == REG_IRQ_EN)) begin
                r_irq_en <= data_in_control[CORES-1:0];
            end
            r_irq <= |((r_done | r_timeout) & r_irq_en);
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (address_control)
            REG_START:   w_rd_data[CORES-1:0] = w_busy;
            REG_DONE:    w_rd_data[CORES-1:0] = r_done;
            REG_IRQ_EN:  w_rd_data[CORES-1:0] = r_irq_en;
            REG_TIMEOUT: w_rd_data[CORES-1:0] = r_timeout;
            default:     w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_data_out <= '0;
        end else if (read_control) begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out_control = r_data_out;
    assign irq              = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mm_control_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_control_multi
// Brief    : Self-checking bench for mm_control_multi (read-data scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_control_multi;

    localparam int CORES      = 4;
    localparam int WIDTH_CTRL = 8;
    localparam int TIMEOUT_W  = 16;
    localparam int TIMEOUT    = 20;

    localparam logic [1:0] A_START   = 2'd0;
    localparam logic [1:0] A_DONE    = 2'd1;
    localparam logic [1:0] A_IRQ_EN  = 2'd2;
    localparam logic [1:0] A_TIMEOUT = 2'd3;

    logic                  clk = 1'b0;
    logic                  reset_sink_reset_n;
    logic [1:0]            address_control;
    logic                  read_control;
    logic                  write_control;
    logic [WIDTH_CTRL-1:0] data_in_control;
    logic [WIDTH_CTRL-1:0] data_out_control;
    logic [CORES-1:0]      interrupt_start;
    logic [CORES-1:0]      interrupt_finish;
    logic                  irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH_CTRL-1:0] exp_q[$];
    string                 tag_q[$];

    mm_control_multi #(
        .CORES      (CORES),
        .WIDTH_CTRL (WIDTH_CTRL),
        .TIMEOUT_W  (TIMEOUT_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset_sink_reset_n (reset_sink_reset_n),
        .address_control    (address_control),
        .read_control       (read_control),
        .write_control      (write_control),
        .data_in_control    (data_in_control),
        .data_out_control   (data_out_control),
        .interrupt_start    (interrupt_start),
        .interrupt_finish   (interrupt_finish),
        .irq                (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Advance one cycle; strobes are single-cycle, read data is scored on return.
    task automatic tick();
        logic was_rd;
        logic [WIDTH_CTRL-1:0] e;
        string t;
        was_rd = read_control;
        @(posedge clk);
        #1;
        read_control     = 1'b0;
        write_control    = 1'b0;
        interrupt_finish = '0;
        if (was_rd) begin
            if (exp_q.size() == 0) begin
                check("rd_queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, {24'd0, data_out_control}, {24'd0, e});
            end
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [WIDTH_CTRL-1:0] e, input string t);
        address_control = a;
        read_control    = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic wr(input logic [1:0] a, input logic [WIDTH_CTRL-1:0] d);
        address_control = a;
        data_in_control = d;
        write_control   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got sim time limit, expected $finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset_sink_reset_n = 1'b0;
        address_control    = '0;
        read_control       = 1'b0;
        write_control      = 1'b0;
        data_in_control    = '0;
        interrupt_finish   = '0;
        repeat (3) tick();
        reset_sink_reset_n = 1'b1;
        tick();

        // Reset state.
        check("rst_dout", {24'd0, data_out_control}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_start", {28'd0, interrupt_start}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], 8'h00, "rst_reg");
            tick();
        end

        // Launch cores 0 and 2, finish 0 then 2 against a same-cycle W1C.
        wr(A_IRQ_EN, 8'h0F); tick();
        rd(A_IRQ_EN, 8'h0F, "irq_en_rd"); tick();
        wr(A_START, 8'h05); tick();                       // t+1
        check("pulse_0_2", {28'd0, interrupt_start}, 32'h5);
        rd(A_START, 8'h05, "busy_05"); tick();            // t+2
        check("pulse_single", {28'd0, interrupt_start}, 32'h0);
        repeat (9) tick();                                // u = t+11
        interrupt_finish = 4'b0001; tick();               // u+1
        check("irq_latency", {31'd0, irq}, 32'h0);
        rd(A_START, 8'h04, "busy_04"); tick();            // u+2
        check("irq_done", {31'd0, irq}, 32'h1);
        interrupt_finish = 4'b0100;
        wr(A_DONE, 8'h04); tick();
        rd(A_DONE, 8'h05, "done_set_wins"); tick();
        rd(A_DONE, 8'h05, "rd_pre_write");
        wr(A_DONE, 8'h05); tick();
        tick();
        check("irq_clear", {31'd0, irq}, 32'h0);
        rd(A_DONE, 8'h00, "done_cleared"); tick();
        rd(A_START, 8'h00, "busy_idle"); tick();

        // Watchdog expiry on core 1.
        wr(A_START, 8'h02); tick();                       // t+1
        check("pulse_1", {28'd0, interrupt_start}, 32'h2);
        repeat (19) tick();                               // t+20
        rd(A_START, 8'h02, "busy_before_to"); tick();     // t+21
        rd(A_TIMEOUT, 8'h00, "to_not_yet"); tick();       // t+22
        rd(A_TIMEOUT, 8'h02, "to_set"); tick();           // t+23
        check("irq_timeout", {31'd0, irq}, 32'h1);
        rd(A_START, 8'h00, "busy_after_to"); tick();
        wr(A_TIMEOUT, 8'h02); tick();
        tick();
        check("irq_to_clear", {31'd0, irq}, 32'h0);

        // Restart request while busy is ignored and does not reset the watchdog.
        wr(A_START, 8'h08); tick();                       // t+1
        check("pulse_3", {28'd0, interrupt_start}, 32'h8);
        repeat (5) tick();                                // t+6
        wr(A_START, 8'h08); tick();                       // t+7
        check("no_repulse", {28'd0, interrupt_start}, 32'h0);
        repeat (14) tick();                               // t+21
        rd(A_TIMEOUT, 8'h00, "to3_not_yet"); tick();      // t+22
        rd(A_TIMEOUT, 8'h08, "to3_orig_wd"); tick();
        wr(A_TIMEOUT, 8'h08); tick();
        tick();

        // Reset while cores 0 and 1 are busy.
        wr(A_START, 8'h03); tick();
        check("pulse_0_1", {28'd0, interrupt_start}, 32'h3);
        tick();
        reset_sink_reset_n = 1'b0;
        tick();
        check("mid_rst_start", {28'd0, interrupt_start}, 32'h0);
        check("mid_rst_dout", {24'd0, data_out_control}, 32'h0);
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        reset_sink_reset_n = 1'b1;
        interrupt_finish   = 4'b0011;
        tick();
        check("post_rst_start", {28'd0, interrupt_start}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], 8'h00, "post_rst_reg");
            tick();
        end
        check("post_rst_irq", {31'd0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
